// File: rtl/mem_stage.sv
// Memory stage of the RV32I pipeline: EX/MEM register, data-memory
// handshake FSM, store lane formatting, load alignment/extension and
// the MEM/WB register. Forwarding taps come straight off EX/MEM.
module mem_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_pc_plus4,
  input  logic [4:0]  i_rd,
  input  logic        i_reg_write,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_jump,
  input  logic [2:0]  i_funct3,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_mask,
  input  logic        i_dmem_ready,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic [4:0]  o_exmem_rd,
  output logic        o_exmem_rw,
  output logic        o_exmem_is_load,
  output logic [31:0] o_exmem_alu,
  output logic        o_wb_valid,
  output logic        o_wb_we,
  output logic        o_wb_trap,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t r_state;

  // EX/MEM pipeline register
  logic        r_valid;
  logic [31:0] r_alu;
  logic [31:0] r_store_data;
  logic [31:0] r_pc_plus4;
  logic [4:0]  r_rd;
  logic        r_reg_write;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_jump;
  logic [2:0]  r_funct3;

  // MEM/WB pipeline register
  logic        r_wb_valid;
  logic        r_wb_we;
  logic        r_wb_trap;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;

  logic        w_is_store;
  logic        w_is_load;
  logic        w_mem_op;
  logic        w_misaligned;
  logic        w_trap;
  logic        w_aligned_op;
  logic        w_req;
  logic        w_stall;
  logic        w_complete;
  logic [31:0] w_wdata;
  logic [3:0]  w_mask;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_fwd_value;
  logic [31:0] w_wb_data;

  // A write flag marks a store; a load is a read that is not also a store.
  assign w_is_store   = r_mem_write;
  assign w_is_load    = r_mem_read & ~r_mem_write;
  assign w_mem_op     = r_valid & (r_mem_read | r_mem_write);
  assign w_misaligned = ((r_funct3[1:0] == 2'b01) & r_alu[0]) |
                        ((r_funct3[1:0] == 2'b10) & (r_alu[1:0] != 2'b00));
  assign w_trap       = w_mem_op & w_misaligned;
  assign w_aligned_op = w_mem_op & ~w_misaligned;
  assign w_req        = w_aligned_op & (r_state == S_IDLE);
  assign w_stall      = w_aligned_op &
                        ~(w_is_store & i_dmem_ready) &
                        ~((r_state == S_WAIT) & i_dmem_rvalid);
  assign w_complete   = r_valid & ~w_stall;
  assign w_fwd_value  = r_jump ? r_pc_plus4 : r_alu;

  // Replicate store data across lanes and build byte enables from size/offset
  always_comb begin
    w_wdata = r_store_data;
    w_mask  = 4'b1111;
    case (r_funct3[1:0])
      2'b00: begin
        w_wdata = {4{r_store_data[7:0]}};
        w_mask  = 4'b0001 << r_alu[1:0];
      end
      2'b01: begin
        w_wdata = {2{r_store_data[15:0]}};
        w_mask  = 4'b0011 << {r_alu[1], 1'b0};
      end
      default: begin
        w_wdata = r_store_data;
        w_mask  = 4'b1111;
      end
    endcase
  end

  // Pick the addressed byte/half of the returned word and extend it
  always_comb begin
    w_byte = i_dmem_rdata[7:0];
    case (r_alu[1:0])
      2'b00:   w_byte = i_dmem_rdata[7:0];
      2'b01:   w_byte = i_dmem_rdata[15:8];
      2'b10:   w_byte = i_dmem_rdata[23:16];
      default: w_byte = i_dmem_rdata[31:24];
    endcase
    w_half = r_alu[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = i_dmem_rdata;
    endcase
  end

  // Writeback value: load data wins, then the link value, then the ALU result
  always_comb begin
    w_wb_data = w_fwd_value;
    if (w_is_load) begin
      w_wb_data = w_load_data;
    end
  end

  // EX/MEM register captures upstream fields whenever the stage is not stalled
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid      <= 1'b0;
      r_alu        <= 32'd0;
      r_store_data <= 32'd0;
      r_pc_plus4   <= 32'd0;
      r_rd         <= 5'd0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_jump       <= 1'b0;
      r_funct3     <= 3'd0;
    end else if (!w_stall) begin
      r_valid      <= i_valid;
      r_alu        <= i_alu_result;
      r_store_data <= i_store_data;
      r_pc_plus4   <= i_pc_plus4;
      r_rd         <= i_rd;
      r_reg_write  <= i_reg_write;
      r_mem_read   <= i_mem_read;
      r_mem_write  <= i_mem_write;
      r_jump       <= i_jump;
      r_funct3     <= i_funct3;
    end
  end

  // Handshake FSM: an accepted load waits for rvalid, stores finish on accept
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && w_is_load && i_dmem_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_dmem_rvalid) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // MEM/WB register takes the completing entry, otherwise shows a bubble
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_trap  <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= 32'd0;
    end else if (w_complete) begin
      r_wb_valid <= 1'b1;
      r_wb_we    <= r_reg_write & ~w_trap & (r_rd != 5'd0);
      r_wb_trap  <= w_trap;
      r_wb_rd    <= r_rd;
      r_wb_data  <= w_wb_data;
    end else begin
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_trap  <= 1'b0;
    end
  end

  assign o_stall         = w_stall;
  assign o_dmem_req      = w_req;
  assign o_dmem_we       = w_req & w_is_store;
  assign o_dmem_addr     = {r_alu[31:2], 2'b00};
  assign o_dmem_wdata    = w_wdata;
  assign o_dmem_mask     = w_req ? w_mask : 4'b0000;
  assign o_exmem_rd      = r_rd;
  assign o_exmem_rw      = r_valid & r_reg_write;
  assign o_exmem_is_load = r_valid & w_is_load;
  assign o_exmem_alu     = w_fwd_value;
  assign o_wb_valid      = r_wb_valid;
  assign o_wb_we         = r_wb_we;
  assign o_wb_trap       = r_wb_trap;
  assign o_wb_rd         = r_wb_rd;
  assign o_wb_data       = r_wb_data;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by
// randomized instructions and memory timing, checked against a
// transaction-level model of the stage.
module tb_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [31:0] i_alu_result;
  logic [31:0] i_store_data;
  logic [31:0] i_pc_plus4;
  logic [4:0]  i_rd;
  logic        i_reg_write;
  logic        i_mem_read;
  logic        i_mem_write;
  logic        i_jump;
  logic [2:0]  i_funct3;
  logic        o_stall;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_mask;
  logic        i_dmem_ready;
  logic        i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;
  logic [4:0]  o_exmem_rd;
  logic        o_exmem_rw;
  logic        o_exmem_is_load;
  logic [31:0] o_exmem_alu;
  logic        o_wb_valid;
  logic        o_wb_we;
  logic        o_wb_trap;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid),
    .i_alu_result(i_alu_result), .i_store_data(i_store_data),
    .i_pc_plus4(i_pc_plus4), .i_rd(i_rd), .i_reg_write(i_reg_write),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_jump(i_jump),
    .i_funct3(i_funct3), .o_stall(o_stall), .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_mask(o_dmem_mask),
    .i_dmem_ready(i_dmem_ready), .i_dmem_rvalid(i_dmem_rvalid),
    .i_dmem_rdata(i_dmem_rdata), .o_exmem_rd(o_exmem_rd),
    .o_exmem_rw(o_exmem_rw), .o_exmem_is_load(o_exmem_is_load),
    .o_exmem_alu(o_exmem_alu), .o_wb_valid(o_wb_valid), .o_wb_we(o_wb_we),
    .o_wb_trap(o_wb_trap), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data)
  );

  always #5 i_clk = ~i_clk;

  // Hard stop in case something upstream of the bounded loops goes wrong
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Access size in bytes implied by funct3
  function automatic int accessSize(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic isMisaligned(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % accessSize(f3)) != 0;
  endfunction

  function automatic logic [31:0] expLoad(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] word);
    logic [31:0] b;
    logic [31:0] h;
    b = (word >> (8 * (addr % 4))) & 32'hFF;
    h = (word >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128)   ? b - 32'd256   : b;
      3'b001:  return (h >= 32768) ? h - 32'd65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] expMask(input logic [2:0] f3, input logic [31:0] addr);
    case (accessSize(f3))
      1:       return 32'd1 << (addr % 4);
      2:       return 32'd3 << (addr % 4);
      default: return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] expWdata(input logic [2:0] f3, input logic [31:0] sdata);
    case (accessSize(f3))
      1:       return (sdata & 32'hFF) * 32'h01010101;
      2:       return (sdata & 32'hFFFF) * 32'h00010001;
      default: return sdata;
    endcase
  endfunction

  // Present one instruction, play the memory side with the given delays and
  // check every cycle until its writeback appears.
  task automatic applyStimulus(
    input string tag, input logic [31:0] alu, input logic [31:0] sdata,
    input logic [31:0] pc4, input logic [4:0] rd, input logic rw,
    input logic mr, input logic mw, input logic jmp, input logic [2:0] f3,
    input int readyDelay, input int rvalidDelay, input logic [31:0] rdata);
    logic isLoad, isStore, memOp, trap, accepted, done, rdyV, rvV, expReq, expStall;
    int reqCount, stallCount, waitLeft, cyc, expStalls;
    logic [31:0] expData;
    isLoad  = mr && !mw;
    isStore = mw;
    memOp   = mr || mw;
    trap    = memOp && isMisaligned(f3, alu);
    expData = isLoad ? expLoad(f3, alu, rdata) : (jmp ? pc4 : alu);

    i_valid = 1'b1; i_alu_result = alu; i_store_data = sdata; i_pc_plus4 = pc4;
    i_rd = rd; i_reg_write = rw; i_mem_read = mr; i_mem_write = mw;
    i_jump = jmp; i_funct3 = f3;
    i_dmem_ready = 1'($urandom_range(0, 1));
    i_dmem_rvalid = 1'($urandom_range(0, 1));
    i_dmem_rdata = $urandom;
    @(posedge i_clk); #1;

    accepted = 1'b0; done = 1'b0; reqCount = 0; stallCount = 0; waitLeft = 0; cyc = 0;
    while (!done && cyc < 40) begin
      expReq = memOp && !trap && !accepted;
      rdyV = expReq ? (reqCount == readyDelay) : 1'($urandom_range(0, 1));
      rvV  = accepted ? (waitLeft == 0) : 1'($urandom_range(0, 1));
      expStall = memOp && !trap && !(isStore && rdyV) && !(accepted && rvV);
      i_dmem_ready  = rdyV;
      i_dmem_rvalid = rvV;
      i_dmem_rdata  = (accepted && rvV) ? rdata : $urandom;
      // Upstream garbage is only offered as valid while stalled, where it must be ignored
      i_valid = expStall ? 1'($urandom_range(0, 1)) : 1'b0;
      i_alu_result = $urandom; i_store_data = $urandom; i_pc_plus4 = $urandom;
      i_rd = 5'($urandom); i_reg_write = 1'($urandom_range(0, 1));
      i_mem_read = 1'($urandom_range(0, 1)); i_mem_write = 1'($urandom_range(0, 1));
      i_jump = 1'($urandom_range(0, 1)); i_funct3 = 3'($urandom);
      @(negedge i_clk);
      checkOutput({tag, ":req"}, o_dmem_req, expReq);
      if (expReq) begin
        checkOutput({tag, ":addr"}, o_dmem_addr, alu - (alu % 4));
        checkOutput({tag, ":we"}, o_dmem_we, isStore);
        if (isStore) begin
          checkOutput({tag, ":mask"}, o_dmem_mask, expMask(f3, alu));
          checkOutput({tag, ":wdata"}, o_dmem_wdata, expWdata(f3, sdata));
        end
      end
      checkOutput({tag, ":stall"}, o_stall, expStall);
      checkOutput({tag, ":wb_bubble"}, o_wb_valid, 1'b0);
      checkOutput({tag, ":fwd_alu"}, o_exmem_alu, jmp ? pc4 : alu);
      checkOutput({tag, ":fwd_rd"}, o_exmem_rd, rd);
      checkOutput({tag, ":fwd_rw"}, o_exmem_rw, rw);
      checkOutput({tag, ":fwd_load"}, o_exmem_is_load, isLoad);
      if (expReq) reqCount++;
      if (o_stall) stallCount++;
      @(posedge i_clk); #1;
      cyc++;
      if (!expStall) done = 1'b1;
      else if (expReq && rdyV && isLoad) begin
        accepted = 1'b1;
        waitLeft = rvalidDelay;
      end else if (accepted) waitLeft--;
    end

    checkOutput({tag, ":completed"}, done, 1'b1);
    if (!memOp || trap) expStalls = 0;
    else if (isStore)   expStalls = readyDelay;
    else                expStalls = readyDelay + 1 + rvalidDelay;
    checkOutput({tag, ":stall_cycles"}, stallCount, expStalls);
    checkOutput({tag, ":wb_valid"}, o_wb_valid, 1'b1);
    checkOutput({tag, ":wb_rd"}, o_wb_rd, rd);
    checkOutput({tag, ":wb_trap"}, o_wb_trap, trap);
    checkOutput({tag, ":wb_we"}, o_wb_we, rw && !trap && (rd != 0));
    if (!trap) checkOutput({tag, ":wb_data"}, o_wb_data, expData);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] addr;
    int kind;

    i_rst = 1'b1; i_valid = 1'b0; i_alu_result = 32'd0; i_store_data = 32'd0;
    i_pc_plus4 = 32'd0; i_rd = 5'd0; i_reg_write = 1'b0; i_mem_read = 1'b0;
    i_mem_write = 1'b0; i_jump = 1'b0; i_funct3 = 3'd0;
    i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'd0;
    #12;
    checkOutput("rst:stall", o_stall, 1'b0);
    checkOutput("rst:req", o_dmem_req, 1'b0);
    checkOutput("rst:we", o_dmem_we, 1'b0);
    checkOutput("rst:mask", o_dmem_mask, 4'd0);
    checkOutput("rst:addr", o_dmem_addr, 32'd0);
    checkOutput("rst:fwd_rw", o_exmem_rw, 1'b0);
    checkOutput("rst:wb_valid", o_wb_valid, 1'b0);
    checkOutput("rst:wb_data", o_wb_data, 32'd0);
    @(negedge i_clk); i_rst = 1'b0;
    @(posedge i_clk); #1;

    applyStimulus("alu", 32'h1234, 32'd0, 32'h8, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 0, 0, 32'd0);
    checkOutput("alu:data_lit", o_wb_data, 32'h1234);
    applyStimulus("sb", 32'h103, 32'h123456AB, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 2, 0, 32'd0);
    applyStimulus("lb", 32'h2, 32'd0, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 0, 0, 32'h00800000);
    checkOutput("lb:data_lit", o_wb_data, 32'hFFFFFF80);
    applyStimulus("lbu", 32'h2, 32'd0, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 0, 0, 32'h00800000);
    checkOutput("lbu:data_lit", o_wb_data, 32'h00000080);
    applyStimulus("lw_mis", 32'h6, 32'd0, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 0, 0, 32'd0);
    applyStimulus("lh_mis", 32'h5, 32'd0, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 0, 0, 32'd0);
    applyStimulus("lhu", 32'h202, 32'd0, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3'b101, 1, 2, 32'h9ABC1234);
    applyStimulus("sh", 32'h2A2, 32'hDEADBEEF, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 0, 0, 32'd0);
    applyStimulus("jal", 32'h800, 32'd0, 32'h40, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 0, 0, 32'd0);
    checkOutput("jal:data_lit", o_wb_data, 32'h40);
    applyStimulus("jal_x0", 32'h800, 32'd0, 32'h40, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 0, 0, 32'd0);

    // Reset while a load is waiting for its data
    i_valid = 1'b1; i_alu_result = 32'h40; i_rd = 5'd4; i_reg_write = 1'b1;
    i_mem_read = 1'b1; i_mem_write = 1'b0; i_jump = 1'b0; i_funct3 = 3'b010;
    i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_dmem_ready = 1'b1;
    @(negedge i_clk);
    checkOutput("rstwait:req", o_dmem_req, 1'b1);
    @(posedge i_clk); #1;
    i_dmem_ready = 1'b0;
    @(negedge i_clk);
    checkOutput("rstwait:stall_in_wait", o_stall, 1'b1);
    i_rst = 1'b1;
    #1;
    checkOutput("rstwait:stall", o_stall, 1'b0);
    checkOutput("rstwait:req", o_dmem_req, 1'b0);
    checkOutput("rstwait:fwd_load", o_exmem_is_load, 1'b0);
    checkOutput("rstwait:fwd_alu", o_exmem_alu, 32'd0);
    checkOutput("rstwait:wb_valid", o_wb_valid, 1'b0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hCAFEF00D;
    @(posedge i_clk); #1;
    checkOutput("rstwait:stray_wb", o_wb_valid, 1'b0);
    checkOutput("rstwait:stray_stall", o_stall, 1'b0);
    i_dmem_rvalid = 1'b0;
    applyStimulus("after_rst", 32'h80, 32'd0, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 0, 1, 32'h13579BDF);

    // Randomized mix of ALU, jump, load and store entries with random memory timing
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 3);
      addr = $urandom;
      if (kind == 2) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % accessSize(f3));
      applyStimulus($sformatf("rnd%0d", n), addr, $urandom, $urandom, 5'($urandom),
                    (kind != 3) ? 1'($urandom_range(0, 1)) : 1'b0,
                    kind == 2, kind == 3, kind == 1, f3,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
